// File: rtl/conf_chain_loader.sv
// Serialises host words LSB-first onto a tile column configuration chain.
// Optional CONF_CHAIN_READBACK_EN adds a CRC-16-CCITT of the displaced CONFret stream.
module conf_chain_loader #(
  parameter int CHAIN_LEN = 160,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              MODE,
  output logic              CONFout,
  input  logic              CONFret,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  bit_count
`ifdef CONF_CHAIN_READBACK_EN
  ,
  output logic [15:0]       readback_crc
`endif
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS =
    (CHAIN_LEN % WORD_W == 0) ? WORD_W : CHAIN_LEN % WORD_W;
  localparam int WL_W = $clog2(NWORDS + 1);
  localparam int SC_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              go;
  logic              stop;
  logic              shift;
  logic              hs;
  logic [WORD_W-1:0] shreg;
  logic [SC_W-1:0]   sh_cnt;
  logic [WL_W-1:0]   words_left;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    stop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = LOAD;
          go        = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt = IDLE;
          stop      = 1'b1;
        end else if (bit_count == CNT_W'(CHAIN_LEN)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready on the last bit so consecutive words stream without a bubble.
  assign s_ready = (state == LOAD) && (words_left != '0)
                && (sh_cnt <= SC_W'(1)) && !abort;
  assign hs      = s_valid && s_ready;
  assign shift   = (state == LOAD) && !abort && (sh_cnt != '0);
  assign busy    = (state == LOAD);
  assign done    = (state == DONE);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      shreg      <= '0;
      sh_cnt     <= '0;
      words_left <= '0;
      bit_count  <= '0;
      MODE       <= 1'b0;
      CONFout    <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      aborted <= stop;
      MODE    <= shift;
      if (shift) begin
        CONFout   <= shreg[0];
        bit_count <= bit_count + CNT_W'(1);
      end
      if (go) begin
        bit_count  <= '0;
        words_left <= WL_W'(NWORDS);
        shreg      <= '0;
        sh_cnt     <= '0;
      end else if (stop) begin
        shreg  <= '0;
        sh_cnt <= '0;
      end else if (hs) begin
        // Final word is trimmed so the chain sees exactly CHAIN_LEN bits.
        shreg      <= s_data;
        sh_cnt     <= (words_left == WL_W'(1)) ? SC_W'(LAST_BITS)
                                               : SC_W'(WORD_W);
        words_left <= words_left - WL_W'(1);
      end else if (shift) begin
        shreg  <= shreg >> 1;
        sh_cnt <= sh_cnt - SC_W'(1);
      end
    end
  end

`ifdef CONF_CHAIN_READBACK_EN
  logic        crc_fb;
  logic [15:0] crc_nxt;

  always_comb begin
    crc_fb  = readback_crc[15] ^ CONFret;
    crc_nxt = {readback_crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)   readback_crc <= '0;
    else if (go)   readback_crc <= 16'hFFFF;
    else if (MODE) readback_crc <= crc_nxt;
  end
`else
  logic unused_confret;
  assign unused_confret = CONFret;
`endif

endmodule

// File: tb/tb_conf_chain_loader.sv
// Directed bench for conf_chain_loader with CHAIN_LEN=40, WORD_W=32.
// Define CONF_CHAIN_READBACK_EN to also check the readback CRC.
module tb_conf_chain_loader;

  localparam int CL = 40;
  localparam int WW = 32;
  localparam int CW = $clog2(CL + 1);

  logic          CLK = 1'b0;
  logic          resetn;
  logic          start;
  logic          abort;
  logic [WW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          MODE;
  logic          CONFout;
  logic          CONFret;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] bit_count;
`ifdef CONF_CHAIN_READBACK_EN
  logic [15:0]   readback_crc;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  conf_chain_loader #(
    .CHAIN_LEN(CL),
    .WORD_W(WW)
  ) dut (
    .CLK(CLK),
    .resetn(resetn),
    .start(start),
    .abort(abort),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .MODE(MODE),
    .CONFout(CONFout),
    .CONFret(CONFret),
    .busy(busy),
    .done(done),
    .aborted(aborted),
    .bit_count(bit_count)
`ifdef CONF_CHAIN_READBACK_EN
    ,
    .readback_crc(readback_crc)
`endif
  );

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap;
    bit          poke;
    logic [39:0] exp;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_zero(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic run_load(input vec_t v);
    logic [39:0] got;
    int          nm;
    int          stalls;
    int          first;
    int          done_at;
    int          bc_done;
    logic        rdy_done;
    int          k;
    int          gapc;
    bit          phs;
`ifdef CONF_CHAIN_READBACK_EN
    logic [15:0] crc_done;
`endif
    got      = '0;
    nm       = 0;
    stalls   = 0;
    first    = -1;
    done_at  = -1;
    bc_done  = 0;
    rdy_done = 1'b1;
    k        = 0;
    gapc     = v.gap;
    phs      = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      if (MODE) begin
        if (nm < 40) got[nm] = CONFout;
        nm++;
        if (first < 0) first = cyc;
      end else if (nm > 0 && nm < 40) begin
        stalls++;
      end
      if (done && done_at < 0) begin
        done_at  = cyc;
        bc_done  = int'(bit_count);
        rdy_done = s_ready;
`ifdef CONF_CHAIN_READBACK_EN
        crc_done = readback_crc;
`endif
      end
      if (done_at >= 0 && cyc >= done_at + 3) break;
      if (phs) k++;
      start   = v.poke && (nm == 20);
      s_valid = 1'b0;
      s_data  = $urandom;
      if (k < 2) begin
        if (k == 1 && gapc > 0 && s_ready) begin
          gapc--;
        end else begin
          s_valid = 1'b1;
          s_data  = (k == 0) ? v.w0 : v.w1;
        end
      end
      #1 phs = s_valid && s_ready;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    chk("bits", 64'(got), 64'(v.exp));
    chk("mode_cycles", 64'(nm), 64'(40));
    chk("stalls", 64'(stalls), 64'(v.gap));
    chk("done_latency", 64'(done_at - first), 64'(40 + v.gap));
    chk("bit_count_done", 64'(bc_done), 64'(40));
    chk("ready_at_done", 64'(rdy_done), 64'(0));
`ifdef CONF_CHAIN_READBACK_EN
    chk("crc_done", 64'(crc_done), 64'(crc_zero(40)));
    chk("crc_hold", 64'(readback_crc), 64'(crc_zero(40)));
`endif
  endtask

  initial begin
    int nm;
    tbl[0] = '{32'hA5A5A5A5, 32'h000000FF, 0, 1'b0, 40'hFF_A5A5A5A5};
    tbl[1] = '{32'hA5A5A5A5, 32'h000000FF, 5, 1'b0, 40'hFF_A5A5A5A5};
    tbl[2] = '{32'h12345678, 32'hFFFFFF00, 0, 1'b1, 40'h00_12345678};
    tbl[3] = '{32'hFFFFFFFF, 32'hABCDEF3C, 2, 1'b0, 40'h3C_FFFFFFFF};

    resetn  = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b1;
    s_data  = '0;
    CONFret = 1'b0;
    repeat (3) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    chk("rst_mode", 64'(MODE), 64'(0));
    chk("rst_confout", 64'(CONFout), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_aborted", 64'(aborted), 64'(0));
    chk("rst_bit_count", 64'(bit_count), 64'(0));
    chk("rst_ready", 64'(s_ready), 64'(0));
    s_valid = 1'b0;

    for (int i = 0; i < 4; i++) run_load(tbl[i]);

    // abort after 10 shifted bits
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hA5A5A5A5;
    nm = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge CLK);
      if (MODE) nm++;
      if (nm == 10) break;
    end
    chk("abort_reach", 64'(nm), 64'(10));
    chk("abort_pre_count", 64'(bit_count), 64'(10));
    abort = 1'b1;
    #1 chk("abort_ready", 64'(s_ready), 64'(0));
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_mode", 64'(MODE), 64'(0));
    chk("abort_pulse", 64'(aborted), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_count", 64'(bit_count), 64'(10));
    @(negedge CLK);
    s_valid = 1'b0;
    chk("abort_pulse_end", 64'(aborted), 64'(0));
    chk("abort_no_done", 64'(done), 64'(0));
    run_load(tbl[0]);

    // start with abort in IDLE
    @(negedge CLK);
    start   = 1'b1;
    abort   = 1'b1;
    s_valid = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'(0));
    chk("sa_ready", 64'(s_ready), 64'(0));
    chk("sa_aborted", 64'(aborted), 64'(0));
    @(negedge CLK);
    chk("sa_idle", 64'(busy), 64'(0));
    s_valid = 1'b0;

    // asynchronous reset mid-load
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h0F0F0F0F;
    nm = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge CLK);
      if (MODE) nm++;
      if (nm == 15) break;
    end
    chk("ar_reach", 64'(nm), 64'(15));
    #2 resetn = 1'b0;
    #1;
    chk("ar_mode", 64'(MODE), 64'(0));
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_ready", 64'(s_ready), 64'(0));
    s_valid = 1'b0;
    #3 resetn = 1'b1;
    @(negedge CLK);
    chk("ar_post", 64'({MODE, CONFout, busy, done, aborted, s_ready}),
        64'(0));
    chk("ar_count", 64'(bit_count), 64'(0));

    run_load(tbl[3]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conf_chain_loader.md
Name: conf_chain_loader

Overview:
- Sequences the serial configuration daisy chain of a fabric tile column (CONFin -> BELs -> switch matrix -> CONFout).
- Accepts configuration words from a host over a valid/ready stream and serialises them LSB-first onto the chain.
- Drives MODE as the per-cycle shift enable and counts exactly CHAIN_LEN bits.
- Signals completion, and supports abort.

Parameters:
- CHAIN_LEN, 160, total configuration bits in the chain; >= 1.
- WORD_W, 32, host word width; >= 2.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- CLK  in  1  configuration clock; also clocks the chain.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begins a load when IDLE, ignored otherwise.
- abort  in  1  level; terminates a load in progress.
- s_data  in  WORD_W  configuration word; bit 0 is shifted first.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts word this cycle.
- MODE  out  1  1 = chain shifts this cycle, 0 = chain holds.
- CONFout  out  1  serial bit into the chain head (tile CONFin).
- CONFret  in  1  serial bit from the chain tail (tile CONFout); used only with the optional feature.
- busy  out  1  high in LOAD.
- done  out  1  1-cycle pulse on completion.
- aborted  out  1  1-cycle pulse when abort ends a load.
- bit_count  out  CNT_W  bits shifted so far in the current/last load.

Behaviour:
- Clocking and reset: one clock, CLK. resetn is asynchronous and active-low. In reset, all outputs are 0, state = IDLE, and the shift register and counters are cleared.
- States and transitions:
  - IDLE: start -> LOAD, bit_count <= 0, words_left <= ceil(CHAIN_LEN/WORD_W).
  - LOAD: stays until bit_count reaches CHAIN_LEN -> DONE; abort -> IDLE.
  - DONE: done=1 for one cycle -> IDLE.
- Word intake:
  - s_ready = LOAD & words_left>0 & (shreg empty | exactly one bit left) & !abort.
  - Handshake occurs on s_valid & s_ready; words_left decrements on each handshake.
  - Ready while the last bit is shifting, so back-to-back words stream at 1 bit/cycle with no bubble.
- Shifting:
  - MODE and CONFout are registered.
  - In each cycle where the shreg holds a bit: MODE<=1, CONFout<=shreg[0], shreg shifts right, bit_count++.
  - If no bit is available (host underflow): MODE<=0 and CONFout holds its value. The chain stalls; no bits are lost.
- Latency: a word handshaken at edge N presents bit 0 on CONFout/MODE after edge N+1.
- Final word: only the low (CHAIN_LEN mod WORD_W) bits are shifted (all WORD_W bits if the remainder is 0). The upper bits are discarded.
- Completion: the cycle after the bit that makes bit_count == CHAIN_LEN, MODE<=0, state -> DONE, and done=1 for one cycle. bit_count holds until the next start.
- Abort: takes priority over a same-cycle handshake.
  - MODE<=0 on the next edge and the shreg is cleared.
  - aborted pulses for 1 cycle; state -> IDLE; done is not asserted.
- Other edge cases:
  - start while LOAD/DONE: ignored.
  - start and abort in the same IDLE cycle: abort wins and the block stays IDLE.
  - Async reset mid-load: MODE drops immediately; the chain contents are undefined and the host must reload.
- busy = (state==LOAD).

Optional Feature:
- Macro: CONF_CHAIN_READBACK_EN.
- Defined:
  - Adds output readback_crc[15:0].
  - On every cycle MODE is 1, CONFret is folded into a CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first shift) captured on the same edge.
  - CRC is reset to 0xFFFF on start; the value holds from DONE until the next start.
  - This lets the host verify the previous configuration as it is displaced.
- Undefined: no readback_crc port, no CRC logic, and CONFret is unconnected internally.

Test Plan:
- CHAIN_LEN=40, WORD_W=32, words 0xA5A5A5A5 then 0x000000FF back-to-back:
  - CONFout shows 40 bits LSB-first with MODE=1 for 40 consecutive cycles.
  - done pulses on cycle 41 after the first MODE; bit_count=40.
  - The upper 24 bits of word 2 are never shifted.
- Same configuration, s_valid dropped for 5 cycles after the first word:
  - MODE=0 for exactly 5 cycles and CONFout holds.
  - Total MODE-high cycles = 40; bit sequence unchanged.
- abort asserted after 10 shifted bits:
  - MODE=0 next cycle, aborted=1 for one cycle, done never asserts, state IDLE.
  - A subsequent start reloads from bit_count=0.
- start pulsed while busy, and start plus abort together in IDLE:
  - The load is unaffected; the block remains IDLE with no s_ready.
- resetn asserted mid-load, asynchronously:
  - MODE, busy and s_ready go 0 without a clock edge; all outputs 0 after release.
- With CONF_CHAIN_READBACK_EN and CONFret tied to 0 for 40 bits:
  - readback_crc equals the reference CRC-16-CCITT of 40 zero bits from 0xFFFF.
  - The value holds after done.
